// File: rtl/memory_sequencer_pkg.sv
// Shared definitions for the memory game sequencer: state encoding, symbol
// width, LED count and the symbol-to-LED decode.
package memory_sequencer_pkg;

    localparam int SYM_W    = 2;
    localparam int NUM_LEDS = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADD      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_INPUT    = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;
    localparam logic [2:0] S_LOSE     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_ADD      = S_ADD,
        ST_SHOW_ON  = S_SHOW_ON,
        ST_SHOW_OFF = S_SHOW_OFF,
        ST_INPUT    = S_INPUT,
        ST_WIN      = S_WIN,
        ST_LOSE     = S_LOSE
    } state_t;

    function automatic logic [NUM_LEDS-1:0] sym_to_led(input logic [SYM_W-1:0] sym);
        return NUM_LEDS'(1) << sym;
    endfunction

endpackage

// File: rtl/memory_pattern_store.sv
// Pattern register file: synchronous write, asynchronous read, cleared by resetn.
import memory_sequencer_pkg::*;

module memory_pattern_store #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SYM_W-1:0]  rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SYM_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && (waddr < ADDR_W'(DEPTH))) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Addresses past the end read as symbol 0 rather than aliasing.
    always_comb begin
        rdata = '0;
        if (raddr < ADDR_W'(DEPTH)) rdata = mem[raddr[AW-1:0]];
    end

endmodule

// File: rtl/memory_sequencer.sv
// Memory game controller: grows a random symbol pattern, plays it back on
// one-hot LEDs and checks the player's button presses against it.
import memory_sequencer_pkg::*;

module memory_sequencer #(
    parameter int MAX_LEN       = 16,
    parameter int ON_TICKS      = 3,
    parameter int OFF_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 20,
    localparam int LVL_W        = $clog2(MAX_LEN + 1)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                tick,
    input  logic                start,
    input  logic [9:0]          rand_word,
    input  logic                btn_valid,
    input  logic [SYM_W-1:0]    btn_code,
    output logic [NUM_LEDS-1:0] led,
    output logic [LVL_W-1:0]    level,
    output logic                awaiting_input,
    output logic                win,
    output logic                lose,
    output logic [2:0]          state_dbg
);

    localparam int CNT_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_MAX   = (TIMEOUT_TICKS > CNT_MAX_A) ? TIMEOUT_TICKS : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mem_we;
    logic [SYM_W-1:0] mem_rdata;
    logic             last_idx;

    memory_pattern_store #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (LVL_W)
    ) u_store (
        .clock  (clock),
        .resetn (resetn),
        .we     (mem_we),
        .waddr  (level_q),
        .wdata  (rand_word[SYM_W-1:0]),
        .raddr  (idx_q),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_idx = (idx_q == level_q - LVL_W'(1));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_ADD;
                    level_d = '0;
                end
            end

            // Ticks arriving here are intentionally dropped.
            ST_ADD: begin
                mem_we  = 1'b1;
                if (level_q < LVL_W'(MAX_LEN)) level_d = level_q + LVL_W'(1);
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHOW_ON;
            end

            ST_SHOW_ON: begin
                if (tick) begin
                    if (cnt_q >= CNT_W'(ON_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW_OFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_SHOW_OFF: begin
                if (tick) begin
                    if (cnt_q >= CNT_W'(OFF_TICKS - 1)) begin
                        cnt_d = '0;
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = ST_INPUT;
                        end else begin
                            idx_d   = idx_q + LVL_W'(1);
                            state_d = ST_SHOW_ON;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // A press takes priority over a timeout expiring in the same cycle.
            ST_INPUT: begin
                if (btn_valid) begin
                    if (btn_code != mem_rdata) begin
                        state_d = ST_LOSE;
                    end else if (!last_idx) begin
                        idx_d = idx_q + LVL_W'(1);
                        cnt_d = '0;
                    end else if (level_q == LVL_W'(MAX_LEN)) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_ADD;
                    end
                end else if (tick) begin
                    if (cnt_q >= CNT_W'(TIMEOUT_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_LOSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        led            = (state_q == ST_SHOW_ON) ? sym_to_led(mem_rdata) : '0;
        level          = level_q;
        awaiting_input = (state_q == ST_INPUT);
        win            = (state_q == ST_WIN);
        lose           = (state_q == ST_LOSE);
        state_dbg      = state_q;
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer: a default build plus a MAX_LEN=2 build
// sharing the same stimulus.
import memory_sequencer_pkg::*;

module tb_memory_sequencer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] rand_word = '0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_code = '0;

    logic [3:0] led;
    logic [4:0] level;
    logic       awaiting_input, win, lose;
    logic [2:0] state_dbg;

    logic [3:0] led2;
    logic [1:0] level2;
    logic       awaiting2, win2, lose2;
    logic [2:0] state2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memory_sequencer dut (
        .clock(clock), .resetn(resetn), .tick(tick), .start(start),
        .rand_word(rand_word), .btn_valid(btn_valid), .btn_code(btn_code),
        .led(led), .level(level), .awaiting_input(awaiting_input),
        .win(win), .lose(lose), .state_dbg(state_dbg)
    );

    memory_sequencer #(.MAX_LEN(2)) dut2 (
        .clock(clock), .resetn(resetn), .tick(tick), .start(start),
        .rand_word(rand_word), .btn_valid(btn_valid), .btn_code(btn_code),
        .led(led2), .level(level2), .awaiting_input(awaiting2),
        .win(win2), .lose(lose2), .state_dbg(state2)
    );

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic t, input logic s, input logic bv, input logic [1:0] bc);
        tick = t; start = s; btn_valid = bv; btn_code = bc;
        @(posedge clock);
        #1;
        tick = 1'b0; start = 1'b0; btn_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, S_IDLE); end
        checks++; if ({led, level, awaiting_input, win, lose} !== 12'd0) begin errors++; $display("FAIL reset_outputs got led=%b level=%0d aw=%b win=%b lose=%b want all 0", led, level, awaiting_input, win, lose); end
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_first_round;
        rand_word = 10'h002;
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        checks++; if (state_dbg !== S_ADD || level !== 5'd0) begin errors++; $display("FAIL start_to_add got state=%0d level=%0d want state=%0d level=0", state_dbg, level, S_ADD); end
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 5'd1 || led !== 4'b0100) begin errors++; $display("FAIL first_led got level=%0d led=%b want level=1 led=0100", level, led); end
        ticks(2);
        checks++; if (led !== 4'b0100) begin errors++; $display("FAIL on_hold got led=%b want 0100", led); end
        ticks(1);
        checks++; if (led !== 4'b0000 || state_dbg !== S_SHOW_OFF) begin errors++; $display("FAIL show_off got led=%b state=%0d want led=0000 state=%0d", led, state_dbg, S_SHOW_OFF); end
        ticks(1);
        checks++; if (awaiting_input !== 1'b1 || led !== 4'b0000) begin errors++; $display("FAIL enter_input got aw=%b led=%b want aw=1 led=0000", awaiting_input, led); end
    endtask

    task automatic test_second_round_and_lose;
        rand_word = 10'h3FD;
        cyc(1'b0, 1'b0, 1'b1, 2'd2);
        checks++; if (state_dbg !== S_ADD) begin errors++; $display("FAIL correct_to_add got state=%0d want %0d", state_dbg, S_ADD); end
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 5'd2 || led !== 4'b0100) begin errors++; $display("FAIL r2_sym0 got level=%0d led=%b want level=2 led=0100", level, led); end
        ticks(4);
        checks++; if (led !== 4'b0010) begin errors++; $display("FAIL r2_sym1 got led=%b want 0010", led); end
        ticks(4);
        checks++; if (awaiting_input !== 1'b1) begin errors++; $display("FAIL r2_input got aw=%b want 1", awaiting_input); end
        cyc(1'b0, 1'b0, 1'b1, 2'd3);
        checks++; if (lose !== 1'b1 || awaiting_input !== 1'b0) begin errors++; $display("FAIL wrong_press got lose=%b aw=%b want lose=1 aw=0", lose, awaiting_input); end
        cyc(1'b1, 1'b0, 1'b1, 2'd2);
        checks++; if (lose !== 1'b1 || level !== 5'd2) begin errors++; $display("FAIL lose_hold got lose=%b level=%0d want lose=1 level=2", lose, level); end
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 5'd1 || lose !== 1'b0 || led !== 4'b0010) begin errors++; $display("FAIL restart got level=%0d lose=%b led=%b want level=1 lose=0 led=0010", level, lose, led); end
    endtask

    task automatic test_timeout;
        ticks(4);
        ticks(19);
        checks++; if (awaiting_input !== 1'b1 || lose !== 1'b0) begin errors++; $display("FAIL pre_timeout got aw=%b lose=%b want aw=1 lose=0", awaiting_input, lose); end
        ticks(1);
        checks++; if (lose !== 1'b1) begin errors++; $display("FAIL timeout got lose=%b want 1", lose); end
    endtask

    task automatic test_press_beats_timeout;
        rand_word = 10'h000;
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        checks++; if (led !== 4'b0001) begin errors++; $display("FAIL sym0_led got led=%b want 0001", led); end
        ticks(4);
        rand_word = 10'h2C7;
        cyc(1'b0, 1'b0, 1'b1, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        ticks(4);
        checks++; if (led !== 4'b1000 || level !== 5'd2) begin errors++; $display("FAIL sym3_led got led=%b level=%0d want led=1000 level=2", led, level); end
        ticks(4);
        ticks(19);
        cyc(1'b1, 1'b0, 1'b1, 2'd0);
        checks++; if (lose !== 1'b0 || awaiting_input !== 1'b1) begin errors++; $display("FAIL press_vs_timeout got lose=%b aw=%b want lose=0 aw=1", lose, awaiting_input); end
        // Only an advanced idx makes code 3 the correct final press.
        cyc(1'b0, 1'b0, 1'b1, 2'd3);
        checks++; if (state_dbg !== S_ADD || level !== 5'd2) begin errors++; $display("FAIL idx_advanced got state=%0d level=%0d want state=%0d level=2", state_dbg, level, S_ADD); end
    endtask

    task automatic test_reset_mid_show;
        rand_word = 10'h001;
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        checks++; if (level !== 5'd3 || led !== 4'b0001) begin errors++; $display("FAIL level3_show got level=%0d led=%b want level=3 led=0001", level, led); end
        ticks(1);
        #2 resetn = 1'b0;
        #1;
        checks++; if (led !== 4'b0000 || level !== 5'd0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL async_reset got led=%b level=%0d state=%0d want 0000 0 %0d", led, level, state_dbg, S_IDLE); end
        cyc(1'b1, 1'b0, 1'b1, 2'd1);
        checks++; if (state_dbg !== S_IDLE || level !== 5'd0) begin errors++; $display("FAIL reset_held got state=%0d level=%0d want %0d 0", state_dbg, level, S_IDLE); end
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 2'd1);
        checks++; if (state_dbg !== S_IDLE || awaiting_input !== 1'b0) begin errors++; $display("FAIL btn_in_idle got state=%0d aw=%b want %0d 0", state_dbg, awaiting_input, S_IDLE); end
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        checks++; if (state_dbg !== S_ADD) begin errors++; $display("FAIL start_after_reset got state=%0d want %0d", state_dbg, S_ADD); end
    endtask

    task automatic test_win;
        resetn = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        resetn = 1'b1;
        rand_word = 10'h002;
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        ticks(4);
        rand_word = 10'h001;
        cyc(1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        ticks(8);
        checks++; if (awaiting2 !== 1'b1 || level2 !== 2'd2) begin errors++; $display("FAIL win_input got aw=%b level=%0d want 1 2", awaiting2, level2); end
        cyc(1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b0, 1'b0, 1'b1, 2'd1);
        checks++; if (win2 !== 1'b1 || level2 !== 2'd2 || led2 !== 4'b0000) begin errors++; $display("FAIL win got win=%b level=%0d led=%b want 1 2 0000", win2, level2, led2); end
        cyc(1'b0, 1'b0, 1'b1, 2'd0);
        checks++; if (win2 !== 1'b1) begin errors++; $display("FAIL win_hold got win=%b want 1", win2); end
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        checks++; if (win2 !== 1'b0 || level2 !== 2'd1) begin errors++; $display("FAIL win_restart got win=%b level=%0d want 0 1", win2, level2); end
    endtask

    initial begin
        test_reset;
        test_first_round;
        test_second_round_and_lose;
        test_timeout;
        test_press_beats_timeout;
        test_reset_mid_show;
        test_win;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_sequencer.md
Name: memory_sequencer

Overview:
- Game-level controller for the memory game.
- Samples the 10-bit random word from the board-clock random generator to grow a 2-bit-symbol pattern, one symbol per round.
- Plays the pattern back on one-hot LEDs, timed by a game tick, then checks player button presses against it.
- Sits between the random generator and the LED/button/score logic; sole owner of the pattern store.

Parameters:
- MAX_LEN, 16, maximum pattern length; reaching it and completing input is a win.
- ON_TICKS, 3, ticks each LED stays lit during playback.
- OFF_TICKS, 1, dark ticks between playback symbols.
- TIMEOUT_TICKS, 20, ticks allowed per player input before a loss.

Ports:
- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-tick enable, synchronous to clock.
- start  in  1  one-cycle pulse; begins a new game from IDLE, WIN or LOSE.
- rand  in  10  random word; only rand[1:0] is used.
- btn_valid  in  1  one-cycle pulse: player pressed a button.
- btn_code  in  2  button index, qualified by btn_valid.
- led  out  4  one-hot playback LEDs; 0 when dark.
- level  out  $clog2(MAX_LEN+1)  current pattern length.
- awaiting_input  out  1  high in INPUT state.
- win  out  1  high in WIN state.
- lose  out  1  high in LOSE state.

Behaviour:
- Reset: state IDLE, led=0, level=0, awaiting_input=0, win=0, lose=0, idx=0, tick counter=0, pattern store cleared to 0.
- A reset mid-operation aborts immediately to the reset values.
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- IDLE/WIN/LOSE -> ADD on start. level is cleared to 0 in the same cycle. WIN/LOSE are held until start.
- ADD (1 cycle):
  - mem[level] <= rand[1:0]; level <= level+1; idx <= 0; tick counter <= 0.
  - Next state SHOW_ON.
  - rand is sampled on the clock edge that leaves ADD. No tick is required.
- SHOW_ON:
  - led = 1 << mem[idx].
  - Counter increments on tick. At the tick that makes it reach ON_TICKS: counter <= 0, go to SHOW_OFF.
- SHOW_OFF:
  - led = 0.
  - After OFF_TICKS ticks, counter <= 0.
  - If idx == level-1: idx <= 0, go to INPUT. Otherwise idx <= idx+1, go to SHOW_ON.
- INPUT:
  - awaiting_input=1, led=0.
  - On btn_valid:
    - btn_code != mem[idx] -> LOSE.
    - Match and idx < level-1 -> idx+1, timeout counter <= 0.
    - Match and idx == level-1 -> WIN if level == MAX_LEN, else ADD.
  - The timeout counter increments on tick while there is no btn_valid. At TIMEOUT_TICKS -> LOSE.
  - btn_valid and timeout expiry in the same cycle: the button wins.
- btn_valid outside INPUT is ignored; the pattern store is untouched.
- start outside IDLE/WIN/LOSE is ignored (no restart mid-game).
- tick and btn_valid may coincide with any state change. Only the current state's rule applies.
- A tick during ADD is dropped.
- Counters saturate; they never wrap. idx never exceeds level-1. level never exceeds MAX_LEN.
- Latency: start to first LED lit = 2 clock cycles. Final correct press to next ADD = 1 cycle.

Decomposition:
- Shared package holds:
  - state encoding (localparams S_IDLE..S_LOSE);
  - symbol width constant SYM_W=2;
  - LED count NUM_LEDS=4.
- One natural sub-module: memory_pattern_store, a MAX_LEN x 2 register file with synchronous write, async read and async clear on resetn.
- The FSM, tick counters and compare stay in memory_sequencer.

Test Plan:
- Reset then start with rand=10'h002 -> one cycle later level=1. led=4'b0100 for 3 ticks, then 0 for 1 tick, then awaiting_input=1.
- Round 1 answered btn_code=2 -> ADD samples rand=10'h3FD (symbol 1); level=2. Playback order is led 0100 then 0010.
- In INPUT at level 2, press btn_code=3 when mem[0]=2 -> lose=1 next cycle. A further btn_valid leaves lose=1. start restarts with level=1.
- In INPUT, no press for 20 ticks -> lose=1 on the 20th tick. A btn_valid in the same cycle as the 20th tick with the correct code -> no loss; idx advances.
- MAX_LEN=2 build: two fully correct rounds -> win=1, level=2, led=0. start -> level=1, win=0.
- Assert resetn low during SHOW_ON at level 3 -> led=0, level=0 and state IDLE while resetn is low. btn_valid is ignored until start.
